// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline sequencer: hold-level codes consumed by
// pc_reg / if_id / id_ex, the sequencer state encoding, and the width of the
// flush countdown.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int          HOLD_FLAG_BUS = 3;
  localparam int          CNT_W         = 3;      // holds FLUSH_CYCLES-1, at most 6
  localparam logic [31:0] ZERO_WORD     = 32'h0;

  // Hold levels, ordered so that a larger code freezes more of the front end.
  typedef enum logic [HOLD_FLAG_BUS-1:0] {
    HOLD_NONE = 3'd0,
    HOLD_PC   = 3'd1,
    HOLD_IF   = 3'd2,
    HOLD_ID   = 3'd3
  } hold_e;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_LDSTALL = 2'd1,
    S_FLUSH   = 2'd2,
    S_HOLD    = 2'd3
  } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_hazard
// Load-use comparator: flags when the instruction in id reads the register that
// the load currently in ex will write. x0 never creates a hazard.
// Ports:
//   ld_ex_i              load in ex
//   ld_rd_ex_i[4:0]      load destination
//   rs1_id_i / rs2_id_i  id source registers
//   rs1_en_id_i / rs2_en_id_i  source is actually read
//   hazard_o             load-use hazard present this cycle
// -----------------------------------------------------------------------------
module pipe_ctrl_hazard (
  input  logic       ld_ex_i,
  input  logic [4:0] ld_rd_ex_i,
  input  logic [4:0] rs1_id_i,
  input  logic [4:0] rs2_id_i,
  input  logic       rs1_en_id_i,
  input  logic       rs2_en_id_i,
  output logic       hazard_o
);

  logic w_rd_nonzero;
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rd_nonzero = (ld_rd_ex_i != 5'd0);
  assign w_rs1_hit    = rs1_en_id_i && (rs1_id_i == ld_rd_ex_i);
  assign w_rs2_hit    = rs2_en_id_i && (rs2_id_i == ld_rd_ex_i);
  assign hazard_o     = ld_ex_i && w_rd_nonzero && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central pipeline sequencer for the five-stage core. Arbitrates hold requests
// (ex, bus, interrupt controller), inserts one bubble on a load-use hazard and
// redirects the PC on jumps, holding id for FLUSH_CYCLES cycles afterwards.
// Priority within a cycle: jump > clint > ex > rib > load-use.
//
// Parameters:
//   FLUSH_CYCLES  cycles of HOLD_ID after a jump, including the jump cycle (1..7)
// Configuration macro:
//   PIPE_CTRL_PERF_EN  adds stall_cnt_o / flush_cnt_o performance counters
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   jump_flag_i/jump_addr_i  redirect request and target from ex
//   hold_ex_i/hold_rib_i/hold_clint_i  hold requests
//   ld_ex_i, ld_rd_ex_i, rs*_id_i, rs*_en_id_i  load-use inputs
//   hold_flag_o[2:0]         hold level (hold_e)
//   stall_flag_o             freeze pc/if_id, bubble into id_ex
//   jump_flag_o/jump_addr_o  redirect to pc_reg
//   stall_cnt_o/flush_cnt_o  perf counters (PIPE_CTRL_PERF_EN only)
// Outputs are combinational from state and inputs and read as zero while rst
// is high.
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     jump_flag_i,
  input  logic [31:0]              jump_addr_i,
  input  logic                     hold_ex_i,
  input  logic                     hold_rib_i,
  input  logic                     hold_clint_i,
  input  logic                     ld_ex_i,
  input  logic [4:0]               ld_rd_ex_i,
  input  logic [4:0]               rs1_id_i,
  input  logic [4:0]               rs2_id_i,
  input  logic                     rs1_en_id_i,
  input  logic                     rs2_en_id_i,
  output logic [HOLD_FLAG_BUS-1:0] hold_flag_o,
  output logic                     stall_flag_o,
  output logic                     jump_flag_o,
  output logic [31:0]              jump_addr_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]              stall_cnt_o,
  output logic [31:0]              flush_cnt_o
`endif
);

  pipe_state_e      r_state;
  pipe_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_hazard;
  logic             w_any_hold;

  pipe_ctrl_hazard u_hazard (
    .ld_ex_i     (ld_ex_i),
    .ld_rd_ex_i  (ld_rd_ex_i),
    .rs1_id_i    (rs1_id_i),
    .rs2_id_i    (rs2_id_i),
    .rs1_en_id_i (rs1_en_id_i),
    .rs2_en_id_i (rs2_en_id_i),
    .hazard_o    (w_hazard)
  );

  assign w_any_hold = hold_clint_i || hold_ex_i || hold_rib_i;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic.
  // NOTE: every signal gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (jump_flag_i) begin
      // A jump always restarts the flush, whatever state we were in.
      if (FLUSH_CYCLES > 1) begin
        w_state_nxt = S_FLUSH;
        w_cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
      end else begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = '0;
      end
    end else begin
      unique case (r_state)
        S_FLUSH: begin
          // The cycle that reads cnt == 1 is the last HOLD_ID cycle of the flush.
          // Holds raised meanwhile are masked by HOLD_ID and picked up on exit.
          if (r_cnt <= CNT_W'(1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = w_any_hold ? S_HOLD : S_RUN;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        S_RUN: begin
          if (w_any_hold)    w_state_nxt = S_HOLD;
          else if (w_hazard) w_state_nxt = S_LDSTALL;
          else               w_state_nxt = S_RUN;
        end
        // S_LDSTALL ignores the hazard; S_HOLD leaves as soon as holds drop.
        default: begin
          w_state_nxt = w_any_hold ? S_HOLD : S_RUN;
        end
      endcase
    end
  end

  // Output logic. The hold level follows the live inputs each cycle.
  always_comb begin
    hold_flag_o  = HOLD_NONE;
    stall_flag_o = 1'b0;
    jump_flag_o  = 1'b0;
    jump_addr_o  = ZERO_WORD;
    if (!rst) begin
      if (jump_flag_i) begin
        jump_flag_o = 1'b1;
        jump_addr_o = jump_addr_i;
        hold_flag_o = HOLD_ID;
      end else if (r_state == S_FLUSH) begin
        hold_flag_o = HOLD_ID;
      end else if (hold_clint_i || hold_ex_i) begin
        hold_flag_o = HOLD_ID;
      end else if (hold_rib_i) begin
        hold_flag_o = HOLD_PC;
      end else if ((r_state == S_RUN) && w_hazard) begin
        stall_flag_o = 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_flag_o || (hold_flag_o != HOLD_NONE)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (jump_flag_o)                                r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed self-checking bench for pipe_ctrl with FLUSH_CYCLES = 3. Each step
// drives one cycle of inputs, queues the expected outputs, and compares them on
// the falling edge. Counter checks are built when PIPE_CTRL_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  typedef struct {
    logic [2:0]  hold;
    logic        stall;
    logic        jump;
    logic [31:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        hold_ex_i, hold_rib_i, hold_clint_i;
  logic        ld_ex_i;
  logic [4:0]  ld_rd_ex_i, rs1_id_i, rs2_id_i;
  logic        rs1_en_id_i, rs2_en_id_i;
  logic [2:0]  hold_flag_o;
  logic        stall_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .hold_ex_i    (hold_ex_i),
    .hold_rib_i   (hold_rib_i),
    .hold_clint_i (hold_clint_i),
    .ld_ex_i      (ld_ex_i),
    .ld_rd_ex_i   (ld_rd_ex_i),
    .rs1_id_i     (rs1_id_i),
    .rs2_id_i     (rs2_id_i),
    .rs1_en_id_i  (rs1_en_id_i),
    .rs2_en_id_i  (rs2_en_id_i),
    .hold_flag_o  (hold_flag_o),
    .stall_flag_o (stall_flag_o),
    .jump_flag_o  (jump_flag_o),
    .jump_addr_o  (jump_addr_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt_o  (stall_cnt_o),
    .flush_cnt_o  (flush_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  task automatic idle();
    rst = 1'b0; jump_flag_i = 1'b0; jump_addr_i = 32'h0;
    hold_ex_i = 1'b0; hold_rib_i = 1'b0; hold_clint_i = 1'b0;
    ld_ex_i = 1'b0; ld_rd_ex_i = 5'd0; rs1_id_i = 5'd0; rs2_id_i = 5'd0;
    rs1_en_id_i = 1'b0; rs2_en_id_i = 1'b0;
  endtask

  task automatic set_ld(input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic en1, input logic [4:0] rs2, input logic en2);
    ld_ex_i = ld; ld_rd_ex_i = rd;
    rs1_id_i = rs1; rs1_en_id_i = en1;
    rs2_id_i = rs2; rs2_en_id_i = en2;
  endtask

  // Inputs are already applied; queue expectation, compare on negedge, then
  // advance past the next rising edge.
  task automatic step(input string tag, input logic [2:0] e_hold, input logic e_stall,
                      input logic e_jump, input logic [31:0] e_addr);
    exp_t e;
    exp_q.push_back('{hold: e_hold, stall: e_stall, jump: e_jump, addr: e_addr});
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, ".hold"},  {29'd0, hold_flag_o}, {29'd0, e.hold});
    check({tag, ".stall"}, {31'd0, stall_flag_o}, {31'd0, e.stall});
    check({tag, ".jump"},  {31'd0, jump_flag_o}, {31'd0, e.jump});
    check({tag, ".addr"},  jump_addr_o, e.addr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #1;

    // Reset with toggling inputs: outputs stay at reset values.
    for (int i = 0; i < 2; i++) begin
      rst = 1'b1;
      jump_flag_i = 1'b1; jump_addr_i = $urandom;
      hold_ex_i = i[0]; hold_rib_i = 1'b1; hold_clint_i = ~i[0];
      set_ld(1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1);
      step("reset", 3'd0, 1'b0, 1'b0, 32'h0);
    end
    idle();
    step("post_reset", 3'd0, 1'b0, 1'b0, 32'h0);

    // Jump: three cycles of HOLD_ID, the first with the redirect.
    jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0100;
    step("jump", 3'd3, 1'b0, 1'b1, 32'h100);
    idle();
    step("flush1", 3'd3, 1'b0, 1'b0, 32'h0);
    step("flush2", 3'd3, 1'b0, 1'b0, 32'h0);
    step("flush_done", 3'd0, 1'b0, 1'b0, 32'h0);

    // Load-use on rs2: one stall, then the bubble cycle ignores the hazard.
    set_ld(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
    step("ldu_c1", 3'd0, 1'b1, 1'b0, 32'h0);
    step("ldu_c2", 3'd0, 1'b0, 1'b0, 32'h0);
    idle();
    step("ldu_c3", 3'd0, 1'b0, 1'b0, 32'h0);

    // Load into x0 never stalls.
    set_ld(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) step("ldu_x0", 3'd0, 1'b0, 1'b0, 32'h0);
    idle();

`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk);
    check("flush_cnt", flush_cnt_o, 32'd1);
    check("stall_cnt", stall_cnt_o, 32'd4);
    @(posedge clk);
    #1;
`endif

    // Load-use on rs1; matching rs2 with its enable low does not count.
    set_ld(1'b1, 5'd9, 5'd9, 1'b1, 5'd3, 1'b0);
    step("ldu_rs1", 3'd0, 1'b1, 1'b0, 32'h0);
    idle();
    step("ldu_rs1_b", 3'd0, 1'b0, 1'b0, 32'h0);
    set_ld(1'b1, 5'd3, 5'd9, 1'b1, 5'd3, 1'b0);
    step("ldu_en_off", 3'd0, 1'b0, 1'b0, 32'h0);
    set_ld(1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1);
    step("ldu_no_load", 3'd0, 1'b0, 1'b0, 32'h0);
    idle();

    // rib + ex for 4 cycles, rib alone 2 more.
    hold_rib_i = 1'b1; hold_ex_i = 1'b1;
    for (int i = 0; i < 4; i++) step("hold_ex_rib", 3'd3, 1'b0, 1'b0, 32'h0);
    hold_ex_i = 1'b0;
    for (int i = 0; i < 2; i++) step("hold_rib", 3'd1, 1'b0, 1'b0, 32'h0);
    hold_rib_i = 1'b0;
    step("hold_release", 3'd0, 1'b0, 1'b0, 32'h0);

    // clint hold masks a simultaneous load-use hazard.
    hold_clint_i = 1'b1;
    set_ld(1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    step("clint_vs_ldu", 3'd3, 1'b0, 1'b0, 32'h0);
    idle();
    step("clint_release", 3'd0, 1'b0, 1'b0, 32'h0);

    // Jump and load-use in the same cycle: jump wins.
    jump_flag_i = 1'b1; jump_addr_i = 32'hDEAD_BEE0;
    set_ld(1'b1, 5'd6, 5'd6, 1'b1, 5'd6, 1'b1);
    step("jump_vs_ldu", 3'd3, 1'b0, 1'b1, 32'hDEAD_BEE0);
    idle();
    step("jvl_flush1", 3'd3, 1'b0, 1'b0, 32'h0);
    step("jvl_flush2", 3'd3, 1'b0, 1'b0, 32'h0);
    step("jvl_done", 3'd0, 1'b0, 1'b0, 32'h0);

    // Jump inside a flush restarts the count; also beats a rib hold.
    jump_flag_i = 1'b1; jump_addr_i = 32'h0000_2000;
    step("rejump_a", 3'd3, 1'b0, 1'b1, 32'h2000);
    idle();
    step("rejump_f1", 3'd3, 1'b0, 1'b0, 32'h0);
    jump_flag_i = 1'b1; jump_addr_i = 32'h0000_3000; hold_rib_i = 1'b1;
    step("rejump_b", 3'd3, 1'b0, 1'b1, 32'h3000);
    idle();
    step("rejump_f2", 3'd3, 1'b0, 1'b0, 32'h0);
    step("rejump_f3", 3'd3, 1'b0, 1'b0, 32'h0);
    step("rejump_done", 3'd0, 1'b0, 1'b0, 32'h0);

    // Reset in the middle of a flush: no residual hold afterwards.
    jump_flag_i = 1'b1; jump_addr_i = 32'h0000_4000;
    step("rst_jump", 3'd3, 1'b0, 1'b1, 32'h4000);
    idle();
    rst = 1'b1;
    step("rst_mid", 3'd0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    step("rst_after", 3'd0, 1'b0, 1'b0, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk);
    check("flush_cnt_rst", flush_cnt_o, 32'd0);
    check("stall_cnt_rst", stall_cnt_o, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
